// File: rtl/bch_chien_correct.sv
// Chien-search error corrector: buffers raw codeword bits and flips every bit
// whose Chien lane reports a root, tracking the corrected-bit count per codeword.
package bch_chien_pkg;
    typedef struct packed {
        int M;
        int T;
        int N;
        int K;
        int DATA_BITS;
    } bch_params_t;

    localparam bch_params_t BCH_SANE = '{M: 5, T: 2, N: 31, K: 21, DATA_BITS: 21};
endpackage

module bch_chien_correct #(
    parameter bch_chien_pkg::bch_params_t P = bch_chien_pkg::BCH_SANE,
    parameter int BITS  = 1,
    parameter int DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [BITS-1:0]                   data_in,
    input  logic                              data_wr,
    input  logic [$clog2(P.T+1)-1:0]          err_deg,
    input  logic                              first,
    input  logic [(P.T+1)*P.M*BITS-1:0]       chien,
    output logic [BITS-1:0]                   data_out,
    output logic                              out_valid,
    output logic                              out_last,
    output logic [$clog2(P.T+1):0]            err_count,
    output logic                              done,
    output logic                              fail,
    output logic                              ovf,
    output logic                              unf
);
    localparam int M          = P.M;
    localparam int T          = P.T;
    localparam int DATA_BITS  = P.DATA_BITS;
    localparam int CYCLES     = (DATA_BITS + BITS - 1) / BITS;
    localparam int LAST_LANES = DATA_BITS - (CYCLES - 1) * BITS;
    localparam int DW         = $clog2(T + 1);
    localparam int EW         = DW + 1;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(CYCLES + 1);
    localparam int SW         = EW + BITS;
    localparam int SAT        = (1 << EW) - 1;
    localparam logic [AW:0]     L_FULL    = (AW+1)'(DEPTH);
    localparam logic [BITS-1:0] LAST_KEEP = ~((BITS'(1) << (BITS - LAST_LANES)) - BITS'(1));

    typedef enum logic [1:0] {IDLE, CORRECT, FINISH} state_t;

    // Release of reset is synchronised; assertion stays asynchronous.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cyc, w_idx;
    logic            w_start, w_act, w_last;

    logic [BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic            w_empty, w_full, w_rd_ok, w_wr_ok;
    logic [BITS-1:0] w_word;

    logic [BITS-1:0] w_mask_raw, w_keep, w_mask;
    logic [SW-1:0]   w_pop, w_acc;
    logic [EW-1:0]   w_cnt_nxt;

    logic [BITS-1:0] r_dout;
    logic            r_valid, r_last, r_done, r_fail, r_ovf, r_unf;
    logic [EW-1:0]   r_err;
    logic [DW-1:0]   r_deg;

    // A first pulse during FINISH is not accepted; the stream restarts from IDLE.
    assign w_start = first && (r_state != FINISH);
    assign w_act   = w_start || (r_state == CORRECT);
    assign w_idx   = w_start ? '0 : r_cyc;
    assign w_last  = w_act && (w_idx == CW'(CYCLES - 1));

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_FULL);
    assign w_rd_ok = w_act && !w_empty;
    assign w_wr_ok = data_wr && (!w_full || w_rd_ok);
    assign w_word  = w_rd_ok ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= data_in;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (data_wr && !w_wr_ok) r_ovf <= 1'b1;
            if (w_act && w_empty)    r_unf <= 1'b1;
        end
    end

    for (genvar b = 0; b < BITS; b++) begin : g_lane
        logic [M-1:0] w_sum;
        always_comb begin
            w_sum = '0;
            for (int i = 0; i <= T; i++)
                w_sum = w_sum ^ chien[((BITS-b-1)*(T+1)+i)*M +: M];
        end
        assign w_mask_raw[BITS-1-b] = (w_sum == '0);
    end

    // Lanes past DATA_BITS in the final word are padding and never count as errors.
    assign w_keep = (w_idx == CW'(CYCLES - 1)) ? LAST_KEEP : '1;
    assign w_mask = w_mask_raw & w_keep;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < BITS; k++)
            w_pop = w_pop + SW'(w_mask[k]);
        w_acc     = (w_start ? SW'(0) : SW'(r_err)) + w_pop;
        w_cnt_nxt = (w_acc > SW'(SAT)) ? EW'(SAT) : w_acc[EW-1:0];
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, CORRECT: if (w_act) w_state_nxt = w_last ? FINISH : CORRECT;
            FINISH:        w_state_nxt = IDLE;
            default:       w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cyc   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_deg   <= '0;
        end else begin
            r_valid <= w_act;
            r_last  <= w_last;
            r_done  <= (r_state == FINISH);
            if (w_act) begin
                r_dout <= (w_word ^ w_mask) & w_keep;
                r_cyc  <= w_idx + 1'b1;
                r_err  <= w_cnt_nxt;
            end
            if (w_start) begin
                r_deg  <= err_deg;
                r_fail <= 1'b0;
            end else if (r_state == FINISH) begin
                r_fail <= (EW'(r_deg) != r_err) || r_unf;
            end
        end
    end

    assign data_out  = r_dout;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign err_count = r_err;
    assign done      = r_done;
    assign fail      = r_fail;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
endmodule

// File: tb/tb_bch_chien_correct.sv
// Bench for bch_chien_correct (BITS=4): queue-based reference model checked every
// cycle, plus literal expectations for the directed codeword scenarios.
module tb_bch_chien_correct;
    localparam int M         = bch_chien_pkg::BCH_SANE.M;
    localparam int T         = bch_chien_pkg::BCH_SANE.T;
    localparam int DATA_BITS = bch_chien_pkg::BCH_SANE.DATA_BITS;
    localparam int BITS      = 4;
    localparam int DEPTH     = 16;
    localparam int CYCLES    = (DATA_BITS + BITS - 1) / BITS;
    localparam int LAST_LN   = DATA_BITS - (CYCLES - 1) * BITS;
    localparam int DW        = $clog2(T + 1);
    localparam int EW        = DW + 1;
    localparam int SAT       = (1 << EW) - 1;
    localparam int CHW       = (T + 1) * M * BITS;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [BITS-1:0] data_in;
    logic            data_wr;
    logic [DW-1:0]   err_deg;
    logic            first;
    logic [CHW-1:0]  chien;
    logic [BITS-1:0] data_out;
    logic            out_valid, out_last, done, fail, ovf, unf;
    logic [EW-1:0]   err_count;

    bch_chien_correct #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_wr(data_wr),
        .err_deg(err_deg), .first(first), .chien(chien), .data_out(data_out),
        .out_valid(out_valid), .out_last(out_last), .err_count(err_count),
        .done(done), .fail(fail), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Intended error lanes for the current cycle, in data-bit order.
    logic [BITS-1:0] cur_em;

    function automatic logic [CHW-1:0] mk_chien(input logic [BITS-1:0] em);
        logic [CHW-1:0] v;
        logic [M-1:0]   x, t;
        v = '0;
        for (int b = 0; b < BITS; b++) begin
            x = '0;
            for (int i = 0; i < T; i++) begin
                t = M'($urandom);
                v[((BITS-b-1)*(T+1)+i)*M +: M] = t;
                x ^= t;
            end
            if (!em[BITS-1-b]) x ^= M'($urandom_range(1, (1 << M) - 1));
            v[((BITS-b-1)*(T+1)+T)*M +: M] = x;
        end
        return v;
    endfunction

    // Reference model
    logic [BITS-1:0] fifo[$];
    bit              m_ovf, m_unf, m_active, m_finish, m_start, m_act;
    int              m_idx, m_cnt, m_deg;
    logic [BITS-1:0] m_word, m_mask, m_keep;
    logic [BITS-1:0] e_dout;
    bit              e_valid, e_last, e_done, e_fail;
    int              e_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo.delete();
            m_ovf = 0; m_unf = 0; m_active = 0; m_finish = 0;
            m_idx = 0; m_cnt = 0; m_deg = 0;
            e_dout = '0; e_valid = 0; e_last = 0; e_done = 0; e_fail = 0; e_cnt = 0;
        end else begin
            m_start = first && !m_finish;
            m_act   = m_start || m_active;
            e_done  = m_finish;
            if (m_finish) e_fail = (m_cnt != m_deg) || m_unf;
            m_finish = 0;
            e_valid  = m_act;
            e_last   = 0;
            if (m_act) begin
                if (m_start) begin
                    m_idx = 0; m_cnt = 0; m_deg = int'(err_deg); e_fail = 0;
                end
                if (fifo.size() > 0) m_word = fifo.pop_front();
                else begin m_word = '0; m_unf = 1; end
                for (int k = 0; k < BITS; k++)
                    m_keep[k] = (m_idx != CYCLES - 1) || (k >= BITS - LAST_LN);
                m_mask = cur_em & m_keep;
                e_dout = (m_word ^ m_mask) & m_keep;
                m_cnt  = m_cnt + $countones(m_mask);
                if (m_cnt > SAT) m_cnt = SAT;
                e_cnt  = m_cnt;
                if (m_idx == CYCLES - 1) begin
                    e_last = 1; m_active = 0; m_finish = 1;
                end else begin
                    m_active = 1; m_idx++;
                end
            end
            if (data_wr) begin
                if (fifo.size() < DEPTH) fifo.push_back(data_in);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out",  32'(data_out),  32'(e_dout));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("out_last",  32'(out_last),  32'(e_last));
            check("err_count", 32'(err_count), 32'(e_cnt));
            check("done",      32'(done),      32'(e_done));
            check("fail",      32'(fail),      32'(e_fail));
            check("ovf",       32'(ovf),       32'(m_ovf));
            check("unf",       32'(unf),       32'(m_unf));
        end
    end

    task automatic drive(input bit f, input int deg, input logic [BITS-1:0] em,
                         input bit wr, input logic [BITS-1:0] d);
        first   = f;
        err_deg = DW'(deg);
        cur_em  = em;
        chien   = mk_chien(em);
        data_wr = wr;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            drive(0, 0, '0, 0, '0);
            if (done) seen = 1;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    logic [BITS-1:0] wq[$];
    logic [BITS-1:0] ems[CYCLES];

    task automatic clear_ems();
        for (int c = 0; c < CYCLES; c++) ems[c] = '0;
    endtask

    // Pre-writes npre words of wq, streams the rest during correction.
    task automatic run_cw(input string nm, input int deg, input int npre,
                          input int chk_c, input logic [BITS-1:0] chk_v);
        for (int i = 0; i < npre; i++) drive(0, 0, '0, 1, wq[i]);
        for (int c = 0; c < CYCLES; c++) begin
            if (npre + c < wq.size()) drive(c == 0, deg, ems[c], 1, wq[npre + c]);
            else                      drive(c == 0, deg, ems[c], 0, '0);
            if (c == chk_c) check({nm, "_word"}, 32'(data_out), 32'(chk_v));
        end
        check({nm, "_last"}, 32'(out_last), 32'd1);
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1; first = 0; data_wr = 0; data_in = '0; err_deg = '0;
        cur_em = '0; chien = '0;
        #2 reset_n = 0;
        chk_en = 1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_outs", 32'({data_out, out_valid, out_last, err_count, done, fail, ovf, unf}), 32'd0);
        reset_n = 1;
        idle(3);

        // Clean codeword, everything pre-buffered.
        wq = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        clear_ems();
        run_cw("clean", 0, 6, 2, 4'h3);
        check("clean_cnt", 32'(err_count), 32'd0);
        check("clean_fail", 32'(fail), 32'd0);

        // Lane 2 root on cycle 3: bit 1 of word 3 flips (4'h3 -> 4'h1).
        wq = {4'hA, 4'h5, 4'hC, 4'h3, 4'h9, 4'h6};
        clear_ems(); ems[3] = 4'b0010;
        run_cw("one_err", 1, 2, 3, 4'h1);
        check("one_err_cnt", 32'(err_count), 32'd1);
        check("one_err_fail", 32'(fail), 32'd0);

        // Padding lanes on the final cycle are ignored; last word keeps only bit 3.
        wq = {4'h0, 4'h7, 4'hB, 4'hD, 4'h2, 4'hE};
        clear_ems(); ems[1] = 4'b1000; ems[5] = 4'b0111;
        run_cw("pad", 1, 3, 5, 4'h8);
        check("pad_cnt", 32'(err_count), 32'd1);
        check("pad_fail", 32'(fail), 32'd0);

        // Degree 2 but only one root.
        wq = {4'hF, 4'hF, 4'h0, 4'h0, 4'h8, 4'h8};
        clear_ems(); ems[2] = 4'b0001;
        run_cw("short", 2, 6, 2, 4'h1);
        check("short_cnt", 32'(err_count), 32'd1);
        check("short_fail", 32'(fail), 32'd1);

        // Every lane a root: 21 flips saturate the 3-bit counter at 7.
        wq = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < CYCLES; c++) ems[c] = 4'hF;
        run_cw("sat", 2, 6, 0, 4'hF);
        check("sat_cnt", 32'(err_count), 32'd7);
        check("sat_fail", 32'(fail), 32'd1);

        // Abort after three cycles; restart with err_deg re-latched.
        for (int i = 0; i < 6; i++) drive(0, 0, '0, 1, 4'($urandom));
        for (int c = 0; c < 3; c++) drive(c == 0, 2, '0, 1, 4'($urandom));
        for (int c = 0; c < CYCLES; c++) drive(c == 0, 1, (c == 0) ? 4'b0100 : 4'b0000, 0, '0);
        wait_done("abort");
        check("abort_cnt", 32'(err_count), 32'd1);
        check("abort_fail", 32'(fail), 32'd0);

        // Overflow then drain: 16 words held, third codeword reads 2 empty words.
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, '0, 1, 4'($urandom));
        check("ovf_set", 32'(ovf), 32'd1);
        wq.delete();
        clear_ems();
        run_cw("drain1", 0, 0, -1, '0);
        check("drain1_fail", 32'(fail), 32'd0);
        run_cw("drain2", 0, 0, -1, '0);
        check("drain2_unf", 32'(unf), 32'd0);
        ems[5] = 4'b1000;
        run_cw("drain3", 1, 0, 5, 4'h8);
        check("drain3_unf", 32'(unf), 32'd1);
        check("drain3_fail", 32'(fail), 32'd1);
        check("drain3_ovf", 32'(ovf), 32'd1);

        // Reset in the middle of a codeword.
        for (int i = 0; i < 6; i++) drive(0, 0, '0, 1, 4'($urandom));
        for (int c = 0; c < 2; c++) drive(c == 0, 1, 4'b1000, 0, '0);
        #1 reset_n = 0;
        #1 check("async_rst", 32'({data_out, out_valid, out_last, err_count, done, fail, ovf, unf}), 32'd0);
        idle(2);
        reset_n = 1;
        idle(4);
        wq = {4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
        clear_ems(); ems[4] = 4'b0100;
        run_cw("post_rst", 1, 1, 4, 4'h1);
        check("post_rst_cnt", 32'(err_count), 32'd1);
        check("post_rst_fail", 32'(fail), 32'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bch_chien_correct.md
BCH_CHIEN_CORRECT -- requirements
Module: bch_chien_correct

Interface
REQ-001 Parameter P SHALL be the BCH parameter set, default `BCH_SANE`; it defines M, T, N, K and DATA_BITS.
REQ-002 Parameter BITS SHALL be the bits per cycle, default 1; it SHALL match the upstream Chien search instance.
REQ-003 Parameter DEPTH SHALL be the data buffer depth in BITS-wide words, default 16; it SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port data_in, input, BITS: raw received data word; MSB is the first bit in stream order.
REQ-007 Port data_wr, input, 1: writes data_in into the buffer this cycle.
REQ-008 Port err_deg, input, clog2(T+1): degree of sigma for the current codeword; sampled on first.
REQ-009 Port first, input, 1: first valid Chien cycle of a codeword.
REQ-010 Port chien, input, (T+1)*M*BITS: Chien terms, lane-major; lane b, term i is at bits [((BITS-b-1)*(T+1)+i)*M +: M].
REQ-011 Port data_out, output, BITS: corrected data word.
REQ-012 Port out_valid, output, 1: data_out is valid.
REQ-013 Port out_last, output, 1: data_out is the final word of the codeword.
REQ-014 Port err_count, output, clog2(T+1)+1: number of corrected bits in the current codeword.
REQ-015 Port done, output, 1: one-cycle pulse, one cycle after out_last.
REQ-016 Port fail, output, 1: codeword uncorrectable; valid while done=1.
REQ-017 Port ovf, output, 1: sticky flag, set by a write while the buffer is full.
REQ-018 Port unf, output, 1: sticky flag, set by a read while the buffer is empty.

Function
REQ-019 CYCLES SHALL equal ceil(DATA_BITS/BITS).
REQ-020 The buffer SHALL be a DEPTH-word circular FIFO with wrapping read and write pointers and a count from 0 to DEPTH.
REQ-021 A write while full SHALL be dropped and SHALL set ovf.
REQ-022 Simultaneous read and write while full SHALL be legal and SHALL leave the count unchanged.
REQ-023 The FSM states SHALL be IDLE, CORRECT and FINISH.
REQ-024 IDLE SHALL go to CORRECT when first=1; on entry the cycle counter, err_count and fail SHALL clear, and err_deg SHALL be latched.
REQ-025 In CORRECT, one word SHALL be read per cycle, including the first cycle, because the Chien stream cannot stall.
REQ-026 A read while the buffer is empty SHALL return word 0 and SHALL set unf.
REQ-027 Lane b SHALL be in error when the XOR of all T+1 terms of lane b is zero.
REQ-028 The error mask SHALL set bit BITS-1-b for each erroneous lane b.
REQ-029 data_out SHALL equal the read word XOR the mask, registered with one-cycle latency from the first and chien inputs.
REQ-030 In the final cycle, the lanes beyond DATA_BITS SHALL be masked to zero in the mask, in data_out and in the error count.
REQ-031 err_count SHALL add the popcount of the mask each cycle and SHALL saturate at 2^width-1.
REQ-032 After CYCLES reads, the FSM SHALL go to FINISH; out_last SHALL assert with the last out_valid.
REQ-033 FINISH SHALL pulse done, SHALL set fail = (err_count != latched err_deg) OR unf, and SHALL return to IDLE.
REQ-034 first=1 while in CORRECT SHALL abort the current codeword without done and SHALL restart at cycle 0 with err_deg re-latched.
REQ-035 Writes SHALL be accepted in every state.
REQ-036 ovf and unf SHALL clear only on reset.

Reset
REQ-037 While reset_n=0, all outputs, the pointers, the count and the counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-038 The deassertion of reset_n SHALL be synchronised internally; the first active edge SHALL occur at least 2 cycles after release.
REQ-039 Reset in the middle of a codeword SHALL discard the buffer contents with no done pulse.

Verification
REQ-040 Zero errors (all chien lanes nonzero), BITS=1, 8 buffered words -> data_out equals data_in for CYCLES words; done with err_count=0 and fail=0.
REQ-041 BITS=4, lane 2 zero on cycle 3 only, err_deg=1 -> word 3 has bit 1 inverted; err_count=1, fail=0.
REQ-042 Error in a padding lane of the final cycle -> no inversion; err_count unchanged.
REQ-043 err_deg=2 with only one root found -> fail=1 on done.
REQ-044 DEPTH+1 writes with no reads -> ovf=1 and count=DEPTH; first with the buffer empty -> unf=1, data_out=mask, and fail=1.
REQ-045 reset_n low in the middle of CORRECT -> all outputs 0 asynchronously; the next first runs a clean codeword.
